// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types and constants for memory_bwe
package memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/memory_bwe_if.sv
// rtl/memory_bwe_if.sv - request/response bundle for memory_bwe
interface memory_bwe_if
  import memory_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) ();

  logic                          Valid;
  logic                          Ready;
  logic                          RW;
  logic [ADDR_W-1:0]             Addr;
  logic [DATA_W-1:0]             Din;
  logic [byte_lanes(DATA_W)-1:0] BE;
  logic [DATA_W-1:0]             D_OUT;
  logic                          D_VALID;

  modport master (
    output Valid, RW, Addr, Din, BE,
    input  Ready, D_OUT, D_VALID
  );

  modport slave (
    input  Valid, RW, Addr, Din, BE,
    output Ready, D_OUT, D_VALID
  );

endinterface

// File: rtl/mem_clear_seq.sv
// rtl/mem_clear_seq.sv - post-reset array clear counter and CLEAR/RUN FSM
module mem_clear_seq
  import memory_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              run
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= CLEAR;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Leaving CLEAR on the edge that writes the top address makes run rise on that same edge.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        if (CLEAR_ON_RESET) begin
          clr_we = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          if (&addr_q) state_d = RUN;
        end else begin
          state_d = RUN;
        end
      end
      RUN: ;
    endcase
  end

  assign clr_addr = addr_q;
  assign run      = (state_q == RUN);

endmodule

// File: rtl/memory_bwe.sv
// rtl/memory_bwe.sv - single-port memory with byte enables, pipelined read and clear sequencer
module memory_bwe
  import memory_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 8,
  parameter int RD_LAT         = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         CLK,
  input  logic         RESET_N,
  memory_bwe_if.slave  bus
);

  localparam int LANES = byte_lanes(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if ((DATA_W % 8) != 0 || DATA_W <= 0) begin : g_bad_data_w
      $error("memory_bwe: DATA_W must be a positive multiple of 8");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("memory_bwe: RD_LAT must be 1 or 2");
    end
  endgenerate

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              run;

  mem_clear_seq #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .run      (run)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_accept;
  logic              rd_accept;

  assign bus.Ready = run;
  assign wr_accept = bus.Valid && run && bus.RW;
  assign rd_accept = bus.Valid && run && !bus.RW;

  // Single write port: the clear sequencer owns it until run is up.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.BE[k]) mem[bus.Addr][8*k +: 8] <= bus.Din[8*k +: 8];
      end
    end
  end

  logic [DATA_W-1:0] rd1_data;
  logic              rd1_valid;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd1_data  <= '0;
      rd1_valid <= 1'b0;
    end else begin
      rd1_valid <= rd_accept;
      if (rd_accept) rd1_data <= mem[bus.Addr];
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign bus.D_OUT   = rd1_data;
      assign bus.D_VALID = rd1_valid;
    end else begin : g_lat2
      logic [DATA_W-1:0] rd2_data;
      logic              rd2_valid;

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          rd2_data  <= '0;
          rd2_valid <= 1'b0;
        end else begin
          rd2_valid <= rd1_valid;
          if (rd1_valid) rd2_data <= rd1_data;
        end
      end

      assign bus.D_OUT   = rd2_data;
      assign bus.D_VALID = rd2_valid;
    end
  endgenerate

endmodule

// File: tb/tb_memory_bwe.sv
// tb/tb_memory_bwe.sv - randomized self-checking bench for memory_bwe
module tb_memory_bwe;
  import memory_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2 ** AW;
  localparam int LANES = DW / 8;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  logic             valid;
  logic             rw;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    din;
  logic [LANES-1:0] be;

  memory_bwe_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  memory_bwe_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();
  memory_bwe_if #(.DATA_W(DW), .ADDR_W(4))  bus3 ();

  assign bus1.Valid = valid;
  assign bus1.RW    = rw;
  assign bus1.Addr  = addr;
  assign bus1.Din   = din;
  assign bus1.BE    = be;
  assign bus2.Valid = valid;
  assign bus2.RW    = rw;
  assign bus2.Addr  = addr;
  assign bus2.Din   = din;
  assign bus2.BE    = be;
  assign bus3.Valid = 1'b0;
  assign bus3.RW    = 1'b0;
  assign bus3.Addr  = '0;
  assign bus3.Din   = '0;
  assign bus3.BE    = '0;

  memory_bwe #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .CLEAR_ON_RESET(1'b1))
    dut1 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus1));
  memory_bwe #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .CLEAR_ON_RESET(1'b1))
    dut2 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus2));
  memory_bwe #(.DATA_W(DW), .ADDR_W(4), .RD_LAT(1), .CLEAR_ON_RESET(1'b0))
    dut3 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus3));

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] mem_m [DEPTH];
  rd_t           q1[$];
  rd_t           q2[$];
  logic [DW-1:0] last1, last2;
  int            edges;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    edges = 0;
    q1.delete();
    q2.delete();
    last1 = '0;
    last2 = '0;
    foreach (mem_m[i]) mem_m[i] = '0;
  endtask

  // Edges counted since reset release; the array is ready once DEPTH of them have passed.
  task automatic model_edge();
    logic was_ready;
    if (RESET_N) begin
      was_ready = (edges >= DEPTH);
      edges++;
      if (valid && was_ready) begin
        if (rw) begin
          for (int k = 0; k < LANES; k++)
            if (be[k]) mem_m[addr][8*k +: 8] = din[8*k +: 8];
        end else begin
          q1.push_back('{due: edges,     data: mem_m[addr]});
          q2.push_back('{due: edges + 1, data: mem_m[addr]});
        end
      end
    end
  endtask

  task automatic compare_all();
    logic ev1, ev2;
    ev1 = 1'b0;
    ev2 = 1'b0;
    if (q1.size() > 0 && q1[0].due == edges) begin
      ev1   = 1'b1;
      last1 = q1[0].data;
      void'(q1.pop_front());
    end
    if (q2.size() > 0 && q2[0].due == edges) begin
      ev2   = 1'b1;
      last2 = q2[0].data;
      void'(q2.pop_front());
    end
    check_eq("ready_lat1", 64'(bus1.Ready), 64'(edges >= DEPTH));
    check_eq("ready_lat2", 64'(bus2.Ready), 64'(edges >= DEPTH));
    check_eq("ready_noclr", 64'(bus3.Ready), 64'(edges >= 1));
    check_eq("dvalid_lat1", 64'(bus1.D_VALID), 64'(ev1));
    check_eq("dvalid_lat2", 64'(bus2.D_VALID), 64'(ev2));
    check_eq("dout_lat1", 64'(bus1.D_OUT), 64'(last1));
    check_eq("dout_lat2", 64'(bus2.D_OUT), 64'(last2));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic set_req(input logic v, input logic w, input int a, input logic [DW-1:0] d,
                         input logic [LANES-1:0] b);
    valid = v;
    rw    = w;
    addr  = AW'(a);
    din   = d;
    be    = b;
  endtask

  task automatic idle();
    set_req(1'b0, 1'b0, 0, '0, '0);
  endtask

  // Entered at a falling edge; reset lands mid-phase, well clear of any rising edge.
  task automatic async_reset(input string tag);
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    check_eq({tag, "_ready1"},  64'(bus1.Ready),   64'(0));
    check_eq({tag, "_ready2"},  64'(bus2.Ready),   64'(0));
    check_eq({tag, "_dvalid1"}, 64'(bus1.D_VALID), 64'(0));
    check_eq({tag, "_dvalid2"}, 64'(bus2.D_VALID), 64'(0));
    check_eq({tag, "_dout1"},   64'(bus1.D_OUT),   64'(0));
    check_eq({tag, "_dout2"},   64'(bus2.D_OUT),   64'(0));
    idle();
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  initial begin
    idle();
    model_reset();
    #1;
    check_eq("rst_ready", 64'(bus1.Ready), 64'(0));
    check_eq("rst_dvalid", 64'(bus2.D_VALID), 64'(0));
    check_eq("rst_dout", 64'(bus1.D_OUT), 64'(0));
    @(negedge CLK);
    tick();
    tick();
    RESET_N = 1'b1;

    // Writes offered during the clear must be dropped.
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < 10) set_req(1'b1, 1'b1, 0, 32'hFFFF_FFFF, 4'hF);
      else idle();
      tick();
    end

    for (int a = 0; a < DEPTH; a++) begin
      set_req(1'b1, 1'b0, a, '0, '0);
      tick();
    end
    idle();
    tick(); tick(); tick();

    set_req(1'b1, 1'b1, 16, 32'hDEAD_BEEF, 4'b1111); tick();
    set_req(1'b1, 1'b1, 16, 32'h1122_3344, 4'b0101); tick();
    set_req(1'b1, 1'b0, 16, '0, 4'hF);              tick();
    idle(); tick(); tick(); tick();

    set_req(1'b1, 1'b1, 5, 32'hCAFE_F00D, 4'hF); tick();
    set_req(1'b1, 1'b0, 5, '0, '0);             tick();
    idle(); tick(); tick();

    set_req(1'b1, 1'b1, 1, 32'hA, 4'hF); tick();
    set_req(1'b1, 1'b1, 2, 32'hB, 4'hF); tick();
    set_req(1'b1, 1'b1, 3, 32'hC, 4'hF); tick();
    set_req(1'b1, 1'b1, 4, 32'h5, 4'h0); tick();
    for (int a = 1; a <= 4; a++) begin
      set_req(1'b1, 1'b0, a, '0, '0);
      tick();
    end
    idle(); tick(); tick(); tick();

    for (int i = 0; i < 400; i++) begin
      set_req(($urandom % 4) != 0, 1'($urandom % 2),
              ($urandom % 2) != 0 ? int'($urandom % 4) : int'($urandom % DEPTH),
              DW'($urandom), LANES'($urandom));
      tick();
    end

    // Reset with a read still travelling through the pipeline.
    set_req(1'b1, 1'b0, 16, '0, '0);
    tick();
    idle();
    async_reset("rst_midread");

    for (int i = 0; i < 7; i++) tick();
    async_reset("rst_midclear");

    for (int i = 0; i < DEPTH + 3; i++) tick();
    for (int a = 0; a < 8; a++) begin
      set_req(1'b1, 1'b0, a * 4 + 1, '0, '0);
      tick();
    end
    idle(); tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
